// File: rtl/keccak_padder_param.sv
// Keccak/SHA-3 input padder, parametrised on word width, rate and domain byte.
// Collects IN_W-bit message words into a RATE-bit block, applies multi-rate
// padding (domain byte, zero fill, final 0x80) on the last word, and hands
// each complete block to the permutation with a buffer_full / f_ack handshake.
module keccak_padder_param #(
    parameter int          IN_W     = 32,
    parameter int          RATE     = 576,
    parameter logic [7:0]  PAD_BYTE = 8'h01,
    localparam int         WORDS    = RATE / IN_W,
    localparam int         NB       = IN_W / 8,
    localparam int         BN_W     = $clog2(NB)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IN_W-1:0]   in,
    input  logic              in_ready,
    input  logic              is_last,
    input  logic [BN_W-1:0]   byte_num,
    input  logic              f_ack,
    output logic              buffer_full,
    output logic [RATE-1:0]   out,
    output logic              out_last
);

    // Wide enough to hold WORDS itself, so the count after the final slot fits.
    localparam int CNT_W = $clog2(WORDS + 1);

    typedef enum logic [1:0] {
        ST_ACCEPT,
        ST_FULL,
        ST_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RATE-1:0]    out_q, out_d;
    logic               out_last_q, out_last_d;
    logic               buffer_full_q, buffer_full_d;
    logic [IN_W-1:0]    word_pad;

    // On the last word keep bytes below byte_num, insert the pad byte, zero the rest.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        word_pad = in;
        if (is_last) begin
            for (int b = 0; b < NB; b++) begin
                if (b == int'(byte_num)) begin
                    word_pad[IN_W-1-8*b -: 8] = PAD_BYTE;
                end else if (b > int'(byte_num)) begin
                    word_pad[IN_W-1-8*b -: 8] = 8'h00;
                end
            end
        end
    end

    // Next-state logic: accumulate words, close the block, release it on f_ack.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        out_d         = out_q;
        out_last_d    = out_last_q;
        buffer_full_d = buffer_full_q;

        unique case (state_q)
            ST_ACCEPT: begin
                if (in_ready) begin
                    // Slot 0 sits at the top of the block, slot WORDS-1 at the bottom.
                    for (int w = 0; w < WORDS; w++) begin
                        if (cnt_q == CNT_W'(w)) begin
                            out_d[(WORDS-1-w)*IN_W +: IN_W] = word_pad;
                        end
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (is_last) begin
                        // Trailing slots are already zero since the block was
                        // cleared on the previous hand-off; only the final bit is set.
                        out_d[7:0]    = out_d[7:0] | 8'h80;
                        out_last_d    = 1'b1;
                        buffer_full_d = 1'b1;
                        state_d       = ST_FULL;
                    end else if (cnt_q == CNT_W'(WORDS - 1)) begin
                        out_last_d    = 1'b0;
                        buffer_full_d = 1'b1;
                        state_d       = ST_FULL;
                    end
                end
            end
            ST_FULL: begin
                // in_ready is deliberately ignored here; the source holds its word.
                if (f_ack) begin
                    out_d         = '0;
                    cnt_d         = '0;
                    out_last_d    = 1'b0;
                    buffer_full_d = 1'b0;
                    state_d       = out_last_q ? ST_DONE : ST_ACCEPT;
                end
            end
            ST_DONE: begin
                // Message complete: outputs stay cleared until reset.
            end
            default: begin
                state_d = ST_ACCEPT;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_ACCEPT;
            cnt_q         <= '0;
            out_q         <= '0;
            out_last_q    <= 1'b0;
            buffer_full_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            out_q         <= out_d;
            out_last_q    <= out_last_d;
            buffer_full_q <= buffer_full_d;
        end
    end

    assign buffer_full = buffer_full_q;
    assign out         = out_q;
    assign out_last    = out_last_q;

endmodule

// File: tb/tb_keccak_padder_param.sv
// Bench for keccak_padder_param: default 32-bit/576 instance plus a
// 64-bit/1088/SHA-3 instance. Expected blocks are queued at stimulus time and
// compared by per-instance monitors on the rising edge of buffer_full.
module tb_keccak_padder_param;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A: IN_W=32, RATE=576, PAD_BYTE=01
    logic [31:0]   in_a = '0;
    logic          ir_a = 1'b0, last_a = 1'b0, fa_a = 1'b0;
    logic [1:0]    bn_a = '0;
    logic          bf_a, ol_a;
    logic [575:0]  out_a;

    // Instance B: IN_W=64, RATE=1088, PAD_BYTE=06
    logic [63:0]   in_b = '0;
    logic          ir_b = 1'b0, last_b = 1'b0, fa_b = 1'b0;
    logic [2:0]    bn_b = '0;
    logic          bf_b, ol_b;
    logic [1087:0] out_b;

    keccak_padder_param dut_a (
        .clk(clk), .reset(reset_n), .in(in_a), .in_ready(ir_a), .is_last(last_a),
        .byte_num(bn_a), .f_ack(fa_a), .buffer_full(bf_a), .out(out_a), .out_last(ol_a)
    );

    keccak_padder_param #(.IN_W(64), .RATE(1088), .PAD_BYTE(8'h06)) dut_b (
        .clk(clk), .reset(reset_n), .in(in_b), .in_ready(ir_b), .is_last(last_b),
        .byte_num(bn_b), .f_ack(fa_b), .buffer_full(bf_b), .out(out_b), .out_last(ol_b)
    );

    typedef struct { logic [575:0] blk; logic last; } exp_a_t;
    typedef struct { logic [1087:0] blk; logic last; } exp_b_t;
    exp_a_t q_a[$];
    exp_b_t q_b[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Compare a block in 64-bit chunks so each report line stays short.
    task automatic check_block(input string name, input logic [1087:0] act,
                               input logic [1087:0] exp, input int chunks);
        for (int i = 0; i < chunks; i++)
            check($sformatf("%s[chunk %0d]", name, i), act[64*i +: 64], exp[64*i +: 64]);
    endtask

    // Monitor A: every new full block must match the oldest queued expectation.
    initial begin
        logic prev;
        exp_a_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bf_a === 1'b1 && !prev) begin
                if (q_a.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL blk_a_unexpected: got block %h, expected none", out_a[63:0]);
                end else begin
                    e = q_a.pop_front();
                    check_block("blk_a", 1088'(out_a), 1088'(e.blk), 9);
                    check("blk_a_last", 64'(ol_a), 64'(e.last));
                end
            end
            prev = (bf_a === 1'b1);
        end
    end

    // Monitor B: same scoreboard for the 64-bit instance.
    initial begin
        logic prev;
        exp_b_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bf_b === 1'b1 && !prev) begin
                if (q_b.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL blk_b_unexpected: got block %h, expected none", out_b[63:0]);
                end else begin
                    e = q_b.pop_front();
                    check_block("blk_b", out_b, e.blk, 17);
                    check("blk_b_last", 64'(ol_b), 64'(e.last));
                end
            end
            prev = (bf_b === 1'b1);
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic send_a(input logic [31:0] w, input logic last, input logic [1:0] bn);
        in_a = w; ir_a = 1'b1; last_a = last; bn_a = bn;
        @(posedge clk); #1;
        ir_a = 1'b0; last_a = 1'b0;
    endtask

    task automatic send_b(input logic [63:0] w, input logic last, input logic [2:0] bn);
        in_b = w; ir_b = 1'b1; last_b = last; bn_b = bn;
        @(posedge clk); #1;
        ir_b = 1'b0; last_b = 1'b0;
    endtask

    task automatic ack_a(input string tag);
        fa_a = 1'b1;
        @(posedge clk); #1;
        fa_a = 1'b0;
        check({tag, "_bf_after_ack"}, 64'(bf_a), 64'd0);
        check({tag, "_out_zero_after_ack"}, 64'(out_a == '0), 64'd1);
    endtask

    task automatic pulse_reset();
        #3 reset_n = 1'b0;
        #1;
        check("rst_bf_a", 64'(bf_a), 64'd0);
        check("rst_out_a_zero", 64'(out_a == '0), 64'd1);
        check("rst_last_a", 64'(ol_a), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        exp_a_t ea;
        exp_b_t eb;

        repeat (2) @(posedge clk);
        #1;
        check("reset_bf_a", 64'(bf_a), 64'd0);
        check("reset_out_a_zero", 64'(out_a == '0), 64'd1);
        check("reset_bf_b", 64'(bf_b), 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Test 1: "Hello, world" then a pad-only last word in slot 3
        ea.blk = '0;
        ea.blk[575 -: 96] = {32'h4865_6c6c, 32'h6f2c_2077, 32'h6f72_6c64};
        ea.blk[479:472] = 8'h01;
        ea.blk[7:0] = 8'h80;
        ea.last = 1'b1;
        q_a.push_back(ea);
        send_a(32'h4865_6c6c, 1'b0, 2'd0);
        send_a(32'h6f2c_2077, 1'b0, 2'd0);
        send_a(32'h6f72_6c64, 1'b0, 2'd0);
        check("t1_bf_before_last", 64'(bf_a), 64'd0);
        send_a(32'h0000_0000, 1'b1, 2'd0);
        check("t1_bf_after_last", 64'(bf_a), 64'd1);
        @(posedge clk); #1;
        ack_a("t1");
        pulse_reset();

        // Test 2: 17 data words then last word with 3 bytes in slot 17
        ea.blk = '0;
        for (int i = 0; i < 17; i++) ea.blk[575 - 32*i -: 32] = 32'h1000_0000 + 32'(i);
        ea.blk[31:0] = 32'hA1B2_C381;
        ea.last = 1'b1;
        q_a.push_back(ea);
        for (int i = 0; i < 17; i++) send_a(32'h1000_0000 + 32'(i), 1'b0, 2'd0);
        check("t2_bf_before_last", 64'(bf_a), 64'd0);
        send_a(32'hA1B2_C3FF, 1'b1, 2'd3);
        check("t2_bf_after_last", 64'(bf_a), 64'd1);
        ack_a("t2");
        pulse_reset();

        // Test 3: exact-fill block, hold during FULL, then pad-only block
        ea.blk = '0;
        for (int i = 0; i < 18; i++) ea.blk[575 - 32*i -: 32] = 32'h2000_0000 + 32'(i);
        ea.last = 1'b0;
        q_a.push_back(ea);
        for (int i = 0; i < 18; i++) send_a(32'h2000_0000 + 32'(i), 1'b0, 2'd0);
        check("t3_bf_full", 64'(bf_a), 64'd1);
        check("t3_not_last", 64'(ol_a), 64'd0);
        in_a = 32'hDEAD_BEEF; ir_a = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("t3_bf_held", 64'(bf_a), 64'd1);
        check("t3_top_stable", out_a[575:512], {32'h2000_0000, 32'h2000_0001});
        check("t3_bottom_stable", out_a[63:0], {32'h2000_0010, 32'h2000_0011});
        fa_a = 1'b1;
        @(posedge clk); #1;
        fa_a = 1'b0; ir_a = 1'b0;
        check("t3_bf_after_ack", 64'(bf_a), 64'd0);
        check("t3_out_zero_after_ack", 64'(out_a == '0), 64'd1);
        ea.blk = '0;
        ea.blk[575:568] = 8'h01;
        ea.blk[7:0] = 8'h80;
        ea.last = 1'b1;
        q_a.push_back(ea);
        send_a(32'h0000_0000, 1'b1, 2'd0);
        check("t3_pad_bf", 64'(bf_a), 64'd1);
        ack_a("t3_pad");

        // DONE: further words and stray acks are ignored
        send_a(32'h1122_3344, 1'b0, 2'd0);
        send_a(32'h5566_7788, 1'b1, 2'd1);
        check("done_bf", 64'(bf_a), 64'd0);
        check("done_out_zero", 64'(out_a == '0), 64'd1);
        check("done_last", 64'(ol_a), 64'd0);
        fa_a = 1'b1;
        @(posedge clk); #1;
        fa_a = 1'b0;
        check("done_ack_bf", 64'(bf_a), 64'd0);
        @(posedge clk); #1;
        check("done_ack_out_zero", 64'(out_a == '0), 64'd1);

        // Test 4: reset mid-block discards partial data; next word goes to slot 0
        pulse_reset();
        for (int i = 0; i < 5; i++) send_a(32'h3000_0000 + 32'(i), 1'b0, 2'd0);
        check("t4_partial_top", out_a[575:512], {32'h3000_0000, 32'h3000_0001});
        pulse_reset();
        ea.blk = '0;
        ea.blk[575 -: 32] = 32'hC0FF_0100;
        ea.blk[7:0] = 8'h80;
        ea.last = 1'b1;
        q_a.push_back(ea);
        send_a(32'hC0FF_EE99, 1'b1, 2'd2);
        check("t4_bf", 64'(bf_a), 64'd1);
        ack_a("t4");

        // Test 5: 64-bit SHA-3 instance, single 3-byte message "abc"
        eb.blk = '0;
        eb.blk[1087 -: 32] = 32'h6162_6306;
        eb.blk[7:0] = 8'h80;
        eb.last = 1'b1;
        q_b.push_back(eb);
        check("t5_bf_before", 64'(bf_b), 64'd0);
        send_b(64'h6162_633F_3F3F_3F3F, 1'b1, 3'd3);
        check("t5_bf_after", 64'(bf_b), 64'd1);
        @(posedge clk); #1;
        fa_b = 1'b1;
        @(posedge clk); #1;
        fa_b = 1'b0;
        check("t5_bf_after_ack", 64'(bf_b), 64'd0);
        check("t5_out_zero", 64'(out_b == '0), 64'd1);

        repeat (2) @(posedge clk);
        #1;
        check("q_a_drained", 64'(q_a.size()), 64'd0);
        check("q_b_drained", 64'(q_b.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
